alu_rs: RTL and testbench
=========================

ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 clr  in  1  synchronous flush (misprediction), active-high.
REQ-004 ALUen  in  1  dispatcher writes one ALU-class instruction this cycle.
REQ-005 op  in  OP_W  operation code.
REQ-006 operandO / operandT  in  32 each  source values, valid when matching tag == TAG_FREE.
REQ-007 tagO / tagT  in  TAG_W each  producer tag of each source, or TAG_FREE.
REQ-008 tagW  in  TAG_W  destination tag; root field equals ALUfreeTag.
REQ-009 addr  in  32  instruction address.
REQ-010 cdbAluEn, cdbAluTag (TAG_W), cdbAluData (32)  in  ALU result broadcast.
REQ-011 cdbLsEn, cdbLsTag (TAG_W), cdbLsData (32)  in  load result broadcast.
REQ-012 ALUfreeTag  out  TAG_ROOT_W  index of the entry the next dispatch uses.
REQ-013 rsFull  out  1  no free entry; dispatcher stalls.
REQ-014 aluEn, aluOp (OP_W), aluA, aluB, aluAddr (32 each), aluTagW (TAG_W)  out  registered issue to ALU.

Function
REQ-015 Storage: RS_DEPTH=8 entries {valid, op, valO, tagO, valT, tagT, addr, tagW}.
REQ-016 ALUfreeTag = lowest-index entry with valid=0 (registered valid bits only); rsFull=1 and ALUfreeTag=0 when all valid.
REQ-017 ALUen=1 and rsFull=0: write entry ALUfreeTag, valid=1 at the edge.
REQ-018 ALUen=1 while rsFull=1: write ignored, no state change.
REQ-019 Dispatch capture: incoming tag equal to an enabled CDB tag stores that CDB data and TAG_FREE in the same edge.
REQ-020 Wake-up: each valid entry operand whose tag matches an enabled CDB tag takes the CDB data and becomes TAG_FREE at the edge.
REQ-021 Both CDBs carry the same tag (illegal): ALU CDB wins.
REQ-022 Ready = valid and both registered tags TAG_FREE; the lowest-index ready entry issues.
REQ-023 Issue: aluEn=1 and aluOp/aluA/aluB/aluAddr/aluTagW loaded from the entry at the edge; the entry's valid clears at the same edge.
REQ-024 No ready entry: aluEn=0, other issue outputs 0, at the next edge.
REQ-025 Simultaneous issue and dispatch: permitted; the issued slot becomes free only in the following cycle.
REQ-026 Latency: a dispatch with both sources free issues at the second edge after ALUen, with aluEn high one cycle later.
REQ-027 clr=1: all valid bits clear and aluEn=0 at the edge; clr dominates ALUen and CDB.

Reset
REQ-028 rst_n=0: all valid=0, aluEn=0, all issue outputs 0; rsFull=0 and ALUfreeTag=0 follow.
REQ-029 Reset asserted mid-operation discards all entries with no partial issue.

Configuration
REQ-030 Macro ALU_RS_FAST_ISSUE_EN, defined: no registered ready entry plus a dispatch with both sources free after REQ-019 capture -> issue at that edge, entry not written.
REQ-031 Macro ALU_RS_FAST_ISSUE_EN, undefined: every dispatch is written first; REQ-026 latency applies.

Structure
REQ-032 defines.v holds OP_W, TAG_W=5, TAG_ROOT_W=3, RS_DEPTH=8, TAG_FREE=5'b10000, NOP and ALU/LS tag prefixes.
REQ-033 Sub-module rs_prio_enc: 8-input lowest-index encoder with found flag, instantiated twice (free slot, ready select).

Verification
REQ-034 Reset, then dispatch op=ADD, A=5, B=7, both tags free -> aluEn=1 at second edge, aluA=5, aluB=7, entry 0 freed.
REQ-035 Dispatch tagO=ALU tag 3, then cdbAluEn tag 3 data 0x10 -> aluA=0x10 on the following issue.
REQ-036 Dispatch tagT=LS tag 2 while cdbLsEn tag 2 data 9 in the same cycle -> captured, issues with aluB=9, no hang.
REQ-037 Eight dependent dispatches -> rsFull=1; ninth ALUen ignored; one issue -> rsFull=0, ALUfreeTag=freed index.
REQ-038 Entries 1 and 4 woken the same cycle -> entry 1 issues first, entry 4 next cycle.
REQ-039 clr with 5 valid entries -> aluEn=0 next cycle, rsFull=0, ALUfreeTag=0.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared constants, types and the CDB snoop helper for the ALU
// reservation station.
//   Tag layout: {prefix[1:0], root[2:0]}; prefix 2'b00 = ALU producer,
//   2'b01 = load/store producer, TAG_FREE (5'b10000) = operand already holds
//   its value.
package alu_rs_pkg;

  localparam int OP_W       = 4;
  localparam int TAG_W      = 5;
  localparam int TAG_ROOT_W = 3;
  localparam int RS_DEPTH   = 8;

  localparam logic [TAG_W-1:0] TAG_FREE    = 5'b10000;
  localparam logic [1:0]       TAG_PFX_ALU = 2'b00;
  localparam logic [1:0]       TAG_PFX_LS  = 2'b01;

  localparam logic [OP_W-1:0] NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } operand_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    operand_t         o;
    operand_t         t;
    logic [31:0]      addr;
    logic [TAG_W-1:0] tagw;
  } rs_entry_t;

  // Resolve one operand against both result buses. The ALU bus is checked
  // first so that it wins if both buses (illegally) carry the same tag.
  function automatic operand_t snoop(
    input operand_t         cur,
    input logic             alu_en,
    input logic [TAG_W-1:0] alu_tag,
    input logic [31:0]      alu_data,
    input logic             ls_en,
    input logic [TAG_W-1:0] ls_tag,
    input logic [31:0]      ls_data
  );
    operand_t res;
    res = cur;
    if (cur.tag != TAG_FREE) begin
      if (alu_en && (cur.tag == alu_tag)) begin
        res.tag = TAG_FREE;
        res.val = alu_data;
      end else if (ls_en && (cur.tag == ls_tag)) begin
        res.tag = TAG_FREE;
        res.val = ls_data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_prio_enc.sv
// rs_prio_enc: 8-input lowest-index priority encoder.
//   req_i   [7:0] request vector
//   idx_o   [2:0] index of the lowest set bit (0 when none set)
//   found_o       at least one bit of req_i is set
module rs_prio_enc (
  input  logic [7:0] req_i,
  output logic [2:0] idx_o,
  output logic       found_o
);

  // Scan from the top down so the lowest set index is the last write.
  always_comb begin
    idx_o   = 3'd0;
    found_o = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 3'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: 8-entry reservation station feeding one ALU.
//   Inputs : clk, rst_n (async, active-low), clr (sync flush),
//            dispatch port ALUen/op/operandO/operandT/tagO/tagT/tagW/addr,
//            ALU result bus cdbAlu*, load result bus cdbLs*.
//   Outputs: ALUfreeTag (slot the next dispatch uses), rsFull,
//            registered issue port aluEn/aluOp/aluA/aluB/aluAddr/aluTagW.
//   Option : define ALU_RS_FAST_ISSUE_EN to let a fully resolved dispatch
//            bypass storage and issue at its own edge when no stored entry
//            is ready.
// Handshake: dispatch is fire-and-forget; the dispatcher only asserts ALUen
// when rsFull is low (a write while rsFull is high is dropped), and the ALU
// accepts the issue port every cycle aluEn is high (no back-pressure).
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  ALUen,
  input  logic [OP_W-1:0]       op,
  input  logic [31:0]           operandO,
  input  logic [31:0]           operandT,
  input  logic [TAG_W-1:0]      tagO,
  input  logic [TAG_W-1:0]      tagT,
  input  logic [TAG_W-1:0]      tagW,
  input  logic [31:0]           addr,
  input  logic                  cdbAluEn,
  input  logic [TAG_W-1:0]      cdbAluTag,
  input  logic [31:0]           cdbAluData,
  input  logic                  cdbLsEn,
  input  logic [TAG_W-1:0]      cdbLsTag,
  input  logic [31:0]           cdbLsData,
  output logic [TAG_ROOT_W-1:0] ALUfreeTag,
  output logic                  rsFull,
  output logic                  aluEn,
  output logic [OP_W-1:0]       aluOp,
  output logic [31:0]           aluA,
  output logic [31:0]           aluB,
  output logic [31:0]           aluAddr,
  output logic [TAG_W-1:0]      aluTagW
);

  rs_entry_t           entry_q [RS_DEPTH];
  rs_entry_t           entry_d [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [RS_DEPTH-1:0] ready;

  logic                  free_found, rdy_found;
  logic [TAG_ROOT_W-1:0] free_idx, rdy_idx;

  logic             iss_en_q, iss_en_d;
  logic [OP_W-1:0]  iss_op_q, iss_op_d;
  logic [31:0]      iss_a_q, iss_a_d;
  logic [31:0]      iss_b_q, iss_b_d;
  logic [31:0]      iss_addr_q, iss_addr_d;
  logic [TAG_W-1:0] iss_tagw_q, iss_tagw_d;

  operand_t disp_o, disp_t;
  logic     fast_take;

  // Readiness looks only at registered tags, so a wake-up this edge makes
  // the entry eligible one cycle later.
  always_comb begin
    ready = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = valid_q[i] && (entry_q[i].o.tag == TAG_FREE) &&
                 (entry_q[i].t.tag == TAG_FREE);
    end
  end

  rs_prio_enc u_free_enc (
    .req_i   (~valid_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_enc u_rdy_enc (
    .req_i   (ready),
    .idx_o   (rdy_idx),
    .found_o (rdy_found)
  );

  assign rsFull     = ~free_found;
  assign ALUfreeTag = free_idx;

  always_comb begin
    entry_d    = entry_q;
    valid_d    = valid_q;
    iss_en_d   = 1'b0;
    iss_op_d   = '0;
    iss_a_d    = '0;
    iss_b_d    = '0;
    iss_addr_d = '0;
    iss_tagw_d = '0;
    fast_take  = 1'b0;

    disp_o = snoop({tagO, operandO}, cdbAluEn, cdbAluTag, cdbAluData,
                   cdbLsEn, cdbLsTag, cdbLsData);
    disp_t = snoop({tagT, operandT}, cdbAluEn, cdbAluTag, cdbAluData,
                   cdbLsEn, cdbLsTag, cdbLsData);

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i]) begin
        entry_d[i].o = snoop(entry_q[i].o, cdbAluEn, cdbAluTag, cdbAluData,
                             cdbLsEn, cdbLsTag, cdbLsData);
        entry_d[i].t = snoop(entry_q[i].t, cdbAluEn, cdbAluTag, cdbAluData,
                             cdbLsEn, cdbLsTag, cdbLsData);
      end
    end

`ifdef ALU_RS_FAST_ISSUE_EN
    fast_take = ALUen && free_found && !rdy_found &&
                (disp_o.tag == TAG_FREE) && (disp_t.tag == TAG_FREE);
`endif

    if (rdy_found) begin
      valid_d[rdy_idx] = 1'b0;
      iss_en_d   = 1'b1;
      iss_op_d   = entry_q[rdy_idx].op;
      iss_a_d    = entry_q[rdy_idx].o.val;
      iss_b_d    = entry_q[rdy_idx].t.val;
      iss_addr_d = entry_q[rdy_idx].addr;
      iss_tagw_d = entry_q[rdy_idx].tagw;
    end else if (fast_take) begin
      iss_en_d   = 1'b1;
      iss_op_d   = op;
      iss_a_d    = disp_o.val;
      iss_b_d    = disp_t.val;
      iss_addr_d = addr;
      iss_tagw_d = tagW;
    end

    // The free slot comes from registered valid bits, so it can never be
    // the slot issuing this same edge.
    if (ALUen && free_found && !fast_take) begin
      valid_d[free_idx]      = 1'b1;
      entry_d[free_idx].op   = op;
      entry_d[free_idx].o    = disp_o;
      entry_d[free_idx].t    = disp_t;
      entry_d[free_idx].addr = addr;
      entry_d[free_idx].tagw = tagW;
    end

    if (clr) begin
      valid_d    = '0;
      iss_en_d   = 1'b0;
      iss_op_d   = '0;
      iss_a_d    = '0;
      iss_b_d    = '0;
      iss_addr_d = '0;
      iss_tagw_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      iss_en_q   <= 1'b0;
      iss_op_q   <= '0;
      iss_a_q    <= '0;
      iss_b_q    <= '0;
      iss_addr_q <= '0;
      iss_tagw_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      iss_en_q   <= iss_en_d;
      iss_op_q   <= iss_op_d;
      iss_a_q    <= iss_a_d;
      iss_b_q    <= iss_b_d;
      iss_addr_q <= iss_addr_d;
      iss_tagw_q <= iss_tagw_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign aluEn   = iss_en_q;
  assign aluOp   = iss_op_q;
  assign aluA    = iss_a_q;
  assign aluB    = iss_b_q;
  assign aluAddr = iss_addr_q;
  assign aluTagW = iss_tagw_q;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs (directed scenarios plus a
// randomized run checked against a slot-level model of the station).
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int PW = OP_W + 96 + TAG_W;
`ifdef ALU_RS_FAST_ISSUE_EN
  localparam int DISP_LAT = 1;
`else
  localparam int DISP_LAT = 2;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                  clr, ALUen;
  logic [OP_W-1:0]       op;
  logic [31:0]           operandO, operandT, addr;
  logic [TAG_W-1:0]      tagO, tagT, tagW;
  logic                  cdbAluEn, cdbLsEn;
  logic [TAG_W-1:0]      cdbAluTag, cdbLsTag;
  logic [31:0]           cdbAluData, cdbLsData;
  logic [TAG_ROOT_W-1:0] ALUfreeTag;
  logic                  rsFull, aluEn;
  logic [OP_W-1:0]       aluOp;
  logic [31:0]           aluA, aluB, aluAddr;
  logic [TAG_W-1:0]      aluTagW;
  logic [PW-1:0]         dut_pkt;

  assign dut_pkt = {aluOp, aluA, aluB, aluAddr, aluTagW};

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ALUen(ALUen), .op(op),
    .operandO(operandO), .operandT(operandT), .tagO(tagO), .tagT(tagT),
    .tagW(tagW), .addr(addr),
    .cdbAluEn(cdbAluEn), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
    .cdbLsEn(cdbLsEn), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
    .ALUfreeTag(ALUfreeTag), .rsFull(rsFull), .aluEn(aluEn), .aluOp(aluOp),
    .aluA(aluA), .aluB(aluB), .aluAddr(aluAddr), .aluTagW(aluTagW)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // A station is a table of 8 slots; each edge: pick oldest-index ready slot
  // to issue, resolve pending operands from the buses, fill lowest empty slot.
  bit               m_v[8];
  logic [OP_W-1:0]  m_op[8];
  logic [31:0]      m_a[8], m_b[8], m_addr[8];
  logic [TAG_W-1:0] m_ta[8], m_tb[8], m_tw[8];
  bit               m_en;
  logic [PW-1:0]    m_pkt;

  function automatic int m_free();
    for (int i = 0; i < 8; i++) if (!m_v[i]) return i;
    return -1;
  endfunction

  function automatic int m_ready();
    for (int i = 0; i < 8; i++)
      if (m_v[i] && m_ta[i] == TAG_FREE && m_tb[i] == TAG_FREE) return i;
    return -1;
  endfunction

  function automatic logic [TAG_W+31:0] m_res(logic [TAG_W-1:0] t, logic [31:0] v);
    if (t == TAG_FREE) return {t, v};
    if (cdbAluEn && t == cdbAluTag) return {TAG_FREE, cdbAluData};
    if (cdbLsEn && t == cdbLsTag) return {TAG_FREE, cdbLsData};
    return {t, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_v[i] = 0;
    m_en = 0;
    m_pkt = '0;
  endtask

  task automatic model_edge();
    int f, r;
    bit fast;
    logic [TAG_W-1:0] ta, tb;
    logic [31:0] va, vb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    f = m_free();
    r = m_ready();
    {ta, va} = m_res(tagO, operandO);
    {tb, vb} = m_res(tagT, operandT);
    fast = 0;
`ifdef ALU_RS_FAST_ISSUE_EN
    fast = ALUen && f >= 0 && r < 0 && ta == TAG_FREE && tb == TAG_FREE;
`endif
    for (int i = 0; i < 8; i++) begin
      if (m_v[i]) begin
        {m_ta[i], m_a[i]} = m_res(m_ta[i], m_a[i]);
        {m_tb[i], m_b[i]} = m_res(m_tb[i], m_b[i]);
      end
    end
    m_en = 0;
    m_pkt = '0;
    if (r >= 0) begin
      m_en = 1;
      m_pkt = {m_op[r], m_a[r], m_b[r], m_addr[r], m_tw[r]};
      m_v[r] = 0;
    end else if (fast) begin
      m_en = 1;
      m_pkt = {op, va, vb, addr, tagW};
    end
    if (ALUen && f >= 0 && !fast) begin
      m_v[f] = 1; m_op[f] = op; m_addr[f] = addr; m_tw[f] = tagW;
      m_ta[f] = ta; m_a[f] = va; m_tb[f] = tb; m_b[f] = vb;
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) m_v[i] = 0;
      m_en = 0;
      m_pkt = '0;
    end
    if (m_en) exp_q.push_back(m_pkt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    ALUen = 0; clr = 0; op = NOP; operandO = '0; operandT = '0;
    tagO = TAG_FREE; tagT = TAG_FREE; tagW = '0; addr = '0;
    cdbAluEn = 0; cdbAluTag = '0; cdbAluData = '0;
    cdbLsEn = 0; cdbLsTag = '0; cdbLsData = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic dispatch(logic [OP_W-1:0] o, logic [TAG_W-1:0] ta, logic [31:0] va,
                          logic [TAG_W-1:0] tb, logic [31:0] vb,
                          logic [TAG_W-1:0] tw, logic [31:0] ad);
    ALUen = 1; op = o; tagO = ta; operandO = va; tagT = tb; operandT = vb;
    tagW = tw; addr = ad;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    set_idle();
    model_reset();
    tick();
    tick();
    n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL reset_aluEn: got %0b want 0", aluEn); end
    n_checks++; if (dut_pkt !== '0) begin n_fail++; $display("FAIL reset_issue_bus: got %h want 0", dut_pkt); end
    n_checks++; if (rsFull !== 1'b0) begin n_fail++; $display("FAIL reset_rsFull: got %0b want 0", rsFull); end
    n_checks++; if (ALUfreeTag !== 3'd0) begin n_fail++; $display("FAIL reset_freeTag: got %0d want 0", ALUfreeTag); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    int n;
    dispatch(OP_ADD, TAG_FREE, 32'd5, TAG_FREE, 32'd7, {TAG_PFX_ALU, 3'd0}, 32'h100);
    tick();
    set_idle();
`ifndef ALU_RS_FAST_ISSUE_EN
    n_checks++; if (ALUfreeTag !== 3'd1) begin n_fail++; $display("FAIL basic_slot_taken: got %0d want 1", ALUfreeTag); end
`endif
    n = 1;
    while (aluEn !== 1'b1 && n < 5) begin tick(); n++; end
    n_checks++; if (n != DISP_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d edges want %0d", n, DISP_LAT); end
    n_checks++; if (aluOp !== OP_ADD || aluA !== 32'd5 || aluB !== 32'd7)
      begin n_fail++; $display("FAIL basic_operands: got op=%0d A=%0d B=%0d want op=1 A=5 B=7", aluOp, aluA, aluB); end
    n_checks++; if (aluAddr !== 32'h100 || aluTagW !== 5'd0)
      begin n_fail++; $display("FAIL basic_addr_tag: got addr=%h tag=%h want 100/0", aluAddr, aluTagW); end
    n_checks++; if (ALUfreeTag !== 3'd0 || rsFull !== 1'b0)
      begin n_fail++; $display("FAIL basic_freed: got free=%0d full=%0b want 0/0", ALUfreeTag, rsFull); end
    tick();
    n_checks++; if (aluEn !== 1'b0 || dut_pkt !== '0)
      begin n_fail++; $display("FAIL basic_idle: got en=%0b bus=%h want 0/0", aluEn, dut_pkt); end
  endtask

  task automatic test_wakeup();
    dispatch(OP_SUB, {TAG_PFX_ALU, 3'd3}, 32'hdead, TAG_FREE, 32'd2, {TAG_PFX_ALU, 3'd0}, 32'h200);
    tick();
    set_idle();
    n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL wake_pending: got %0b want 0", aluEn); end
    cdbAluEn = 1; cdbAluTag = {TAG_PFX_ALU, 3'd3}; cdbAluData = 32'h10;
    tick();
    set_idle();
    n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL wake_same_edge: got %0b want 0", aluEn); end
    tick();
    n_checks++; if (aluEn !== 1'b1 || aluA !== 32'h10 || aluB !== 32'd2)
      begin n_fail++; $display("FAIL wake_issue: got en=%0b A=%h B=%h want 1/10/2", aluEn, aluA, aluB); end
    tick();
  endtask

  task automatic test_capture();
    int n;
    dispatch(OP_AND, TAG_FREE, 32'd1, {TAG_PFX_LS, 3'd2}, 32'd0, {TAG_PFX_ALU, 3'd0}, 32'h300);
    cdbLsEn = 1; cdbLsTag = {TAG_PFX_LS, 3'd2}; cdbLsData = 32'd9;
    tick();
    set_idle();
    n = 1;
    while (aluEn !== 1'b1 && n < 5) begin tick(); n++; end
    n_checks++; if (n != DISP_LAT) begin n_fail++; $display("FAIL capture_latency: got %0d edges want %0d", n, DISP_LAT); end
    n_checks++; if (aluB !== 32'd9 || aluA !== 32'd1)
      begin n_fail++; $display("FAIL capture_value: got A=%0d B=%0d want 1/9", aluA, aluB); end
    tick();
    // both buses carry the same tag: the ALU bus value must be taken
    dispatch(OP_OR, {TAG_PFX_ALU, 3'd6}, 32'd0, TAG_FREE, 32'd4, {TAG_PFX_ALU, 3'd0}, 32'h304);
    cdbAluEn = 1; cdbAluTag = {TAG_PFX_ALU, 3'd6}; cdbAluData = 32'hA;
    cdbLsEn = 1; cdbLsTag = {TAG_PFX_ALU, 3'd6}; cdbLsData = 32'hB;
    tick();
    set_idle();
    n = 1;
    while (aluEn !== 1'b1 && n < 5) begin tick(); n++; end
    n_checks++; if (aluEn !== 1'b1 || aluA !== 32'hA)
      begin n_fail++; $display("FAIL cdb_alu_wins: got en=%0b A=%h want 1/a", aluEn, aluA); end
    tick();
  endtask

  task automatic test_full_and_priority();
    for (int i = 0; i < 8; i++) begin
      dispatch(OP_OR, {(i % 2 == 1) ? TAG_PFX_LS : TAG_PFX_ALU, 3'(i)}, 32'd0,
               TAG_FREE, 32'(i), {TAG_PFX_ALU, 3'(i)}, 32'(i * 4));
      tick();
    end
    set_idle();
    n_checks++; if (rsFull !== 1'b1 || ALUfreeTag !== 3'd0)
      begin n_fail++; $display("FAIL full_flag: got full=%0b free=%0d want 1/0", rsFull, ALUfreeTag); end
    dispatch(OP_XOR, TAG_FREE, 32'd1, TAG_FREE, 32'd1, {TAG_PFX_ALU, 3'd0}, 32'h999);
    tick();
    set_idle();
    n_checks++; if (rsFull !== 1'b1 || aluEn !== 1'b0)
      begin n_fail++; $display("FAIL full_ignore: got full=%0b en=%0b want 1/0", rsFull, aluEn); end
    cdbLsEn = 1; cdbLsTag = {TAG_PFX_LS, 3'd3}; cdbLsData = 32'h33;
    tick();
    set_idle();
    tick();
    n_checks++; if (aluEn !== 1'b1 || aluTagW !== 5'd3 || aluA !== 32'h33 || aluB !== 32'd3)
      begin n_fail++; $display("FAIL full_issue: got en=%0b tag=%0d A=%h B=%0d want 1/3/33/3", aluEn, aluTagW, aluA, aluB); end
    n_checks++; if (rsFull !== 1'b0 || ALUfreeTag !== 3'd3)
      begin n_fail++; $display("FAIL full_freed: got full=%0b free=%0d want 0/3", rsFull, ALUfreeTag); end
    // wake entries 1 and 4 together
    cdbLsEn = 1; cdbLsTag = {TAG_PFX_LS, 3'd1}; cdbLsData = 32'h11;
    cdbAluEn = 1; cdbAluTag = {TAG_PFX_ALU, 3'd4}; cdbAluData = 32'h44;
    tick();
    set_idle();
    tick();
    n_checks++; if (aluEn !== 1'b1 || aluTagW !== 5'd1 || aluA !== 32'h11)
      begin n_fail++; $display("FAIL prio_first: got en=%0b tag=%0d A=%h want 1/1/11", aluEn, aluTagW, aluA); end
    tick();
    n_checks++; if (aluEn !== 1'b1 || aluTagW !== 5'd4 || aluA !== 32'h44)
      begin n_fail++; $display("FAIL prio_second: got en=%0b tag=%0d A=%h want 1/4/44", aluEn, aluTagW, aluA); end
    tick();
    n_checks++; if (aluEn !== 1'b0 || ALUfreeTag !== 3'd1)
      begin n_fail++; $display("FAIL prio_after: got en=%0b free=%0d want 0/1", aluEn, ALUfreeTag); end
  endtask

  task automatic test_clr();
    // five entries (0,2,5,6,7) remain; flush while dispatching and broadcasting
    dispatch(OP_ADD, TAG_FREE, 32'd1, TAG_FREE, 32'd2, {TAG_PFX_ALU, 3'd1}, 32'h400);
    cdbAluEn = 1; cdbAluTag = {TAG_PFX_ALU, 3'd0}; cdbAluData = 32'h5;
    clr = 1;
    tick();
    set_idle();
    n_checks++; if (aluEn !== 1'b0 || rsFull !== 1'b0 || ALUfreeTag !== 3'd0)
      begin n_fail++; $display("FAIL clr_flush: got en=%0b full=%0b free=%0d want 0/0/0", aluEn, rsFull, ALUfreeTag); end
    tick();
    n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL clr_no_late_issue: got %0b want 0", aluEn); end
  endtask

  task automatic test_mid_reset();
    dispatch(OP_ADD, TAG_FREE, 32'd3, TAG_FREE, 32'd4, {TAG_PFX_ALU, 3'd0}, 32'h500);
    tick();
    dispatch(OP_SUB, TAG_FREE, 32'd8, TAG_FREE, 32'd1, {TAG_PFX_ALU, 3'd1}, 32'h504);
    tick();
    set_idle();
    rst_n = 0;
    model_reset();
    #2;
    n_checks++; if (aluEn !== 1'b0 || dut_pkt !== '0 || rsFull !== 1'b0 || ALUfreeTag !== 3'd0)
      begin n_fail++; $display("FAIL midreset_async: got en=%0b bus=%h full=%0b free=%0d want all 0", aluEn, dut_pkt, rsFull, ALUfreeTag); end
    tick();
    rst_n = 1;
    tick();
    tick();
    n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL midreset_no_issue: got %0b want 0", aluEn); end
  endtask

  function automatic logic [TAG_W-1:0] rand_src_tag();
    logic [1:0] p;
    if ($urandom_range(0, 1) == 0) return TAG_FREE;
    p = 2'($urandom_range(0, 1));
    return {p, 3'($urandom_range(0, 7))};
  endfunction

  task automatic test_random();
    int f;
    logic [PW-1:0] e;
    logic [1:0] p;
    exp_q.delete();
    for (int c = 0; c < 500; c++) begin
      set_idle();
      f = m_free();
      if ($urandom_range(0, 99) < 60)
        dispatch(4'($urandom_range(1, 5)), rand_src_tag(), $urandom(), rand_src_tag(), $urandom(),
                 {TAG_PFX_ALU, 3'((f < 0) ? 0 : f)}, $urandom());
      if ($urandom_range(0, 99) < 45) begin
        p = 2'($urandom_range(0, 1));
        cdbAluEn = 1; cdbAluTag = {p, 3'($urandom_range(0, 7))}; cdbAluData = $urandom();
      end
      if ($urandom_range(0, 99) < 45) begin
        p = 2'($urandom_range(0, 1));
        cdbLsEn = 1; cdbLsTag = {p, 3'($urandom_range(0, 7))}; cdbLsData = $urandom();
      end
      clr = ($urandom_range(0, 49) == 0);
      tick();
      f = m_free();
      n_checks++; if (aluEn !== m_en) begin n_fail++; $display("FAIL rand_aluEn c=%0d: got %0b want %0b", c, aluEn, m_en); end
      n_checks++; if (rsFull !== (f < 0)) begin n_fail++; $display("FAIL rand_rsFull c=%0d: got %0b want %0b", c, rsFull, f < 0); end
      n_checks++; if (ALUfreeTag !== 3'((f < 0) ? 0 : f))
        begin n_fail++; $display("FAIL rand_freeTag c=%0d: got %0d want %0d", c, ALUfreeTag, (f < 0) ? 0 : f); end
      if (aluEn === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_issue_unexpected c=%0d: got %h want none", c, dut_pkt);
        end else begin
          e = exp_q.pop_front();
          if (dut_pkt !== e) begin n_fail++; $display("FAIL rand_issue c=%0d: got %h want %h", c, dut_pkt, e); end
        end
      end else begin
        n_checks++; if (dut_pkt !== '0) begin n_fail++; $display("FAIL rand_idle_bus c=%0d: got %h want 0", c, dut_pkt); end
      end
    end
    set_idle();
    tick();
    n_checks++; if (exp_q.size() > 1 || (exp_q.size() == 1 && aluEn !== 1'b1))
      begin n_fail++; $display("FAIL rand_leftover: got %0d queued issues want 0", exp_q.size()); end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_capture();
    test_full_and_priority();
    test_clr();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
